// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter slice:
//               arbiter state encoding, default character width and a
//               ceiling-log2 helper used to size pointers and counters.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam int DEF_DBIT = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Client + serializer handshake bundle of the UART transmit
//               arbiter.
// Ports       : req/din/last  - per-client byte stream (din slice i*DBIT)
//               ack/grant     - per-client accept pulse / one-hot owner
//               busy          - transmitter owned
//               tx_start/tx_data/tx_done - uart_tx start, d_in, done_tick
//               slave modport : arbiter side; master modport : environment
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N    = 4,
  parameter int DBIT = 8
);
  logic [N-1:0]      req;
  logic [N*DBIT-1:0] din;
  logic [N-1:0]      last;
  logic [N-1:0]      ack;
  logic [N-1:0]      grant;
  logic              busy;
  logic              tx_start;
  logic [DBIT-1:0]   tx_data;
  logic              tx_done;

  modport master (
    output req, din, last, tx_done,
    input  ack, grant, busy, tx_start, tx_data
  );

  modport slave (
    input  req, din, last, tx_done,
    output ack, grant, busy, tx_start, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
// Ports       : req    (in)  N request bits
//               ptr    (in)  scan start index
//               winner (out) index of the selected request
//               valid  (out) at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx[PW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one uart_tx serializer between N byte-stream clients.
//               Round-robin grants at message granularity: the owner keeps
//               the transmitter until a byte flagged last has been sent.
//               Optional macro UART_ARB_TIMEOUT_EN releases a lock whose
//               owner leaves req low in SEND for TIMEOUT cycles.
// Ports       : clk   (in) system clock
//               reset (in) asynchronous active-high reset
//               bus   (uart_tx_arbiter_if.slave) client and uart_tx handshake
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N       = 4,
  parameter int DBIT    = DEF_DBIT,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? clog2(N) : 1;

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic          lastf;

  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic [N-1:0]  pick_onehot;
  logic [N-1:0]  owner_onehot;
  logic [PW-1:0] next_ptr;

  uart_rr_pick #(.N(N)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_onehot  = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign owner_onehot = {{(N-1){1'b0}}, 1'b1} << owner;
  // Fairness: the client after the releasing owner scans first next time.
  assign next_ptr     = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT) + 1;
  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;
  assign timeout_hit = (idle_cnt == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      lastf        <= 1'b0;
      bus.grant    <= '0;
      bus.busy     <= 1'b0;
      bus.ack      <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      // ack and tx_start are single-cycle pulses.
      bus.ack      <= '0;
      bus.tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      // Only a stalled owner in SEND keeps the count running.
      idle_cnt     <= '0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            bus.grant <= pick_onehot;
            bus.busy  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (bus.req[owner]) begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= bus.din[int'(owner) * DBIT +: DBIT];
            bus.ack      <= owner_onehot;
            lastf        <= bus.last[owner];
            state        <= WAIT;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            ptr       <= next_ptr;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        WAIT: begin
          if (bus.tx_done) begin
            if (lastf) begin
              bus.grant <= '0;
              bus.busy  <= 1'b0;
              ptr       <= next_ptr;
              state     <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_tx` serializer between N byte-stream clients.
- Grants are round-robin at message granularity: a granted client keeps the transmitter until it sends a byte flagged `last`.
- Sits between the banner/message sources and `uart_tx`. It drives `uart_tx`'s `start`/`d_in` and consumes its `done_tick`.

Parameters:
- N, 4, number of requesting clients (2..16)
- DBIT, 8, data bits per character; must match the `uart_tx` instance
- TIMEOUT, 1024, idle-lock cycles before forced release (used only with the optional feature)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  N  client i has a byte valid on its din slice
- din  input  N*DBIT  client i byte on bits [i*DBIT +: DBIT]
- last  input  N  client i's current byte ends its message
- ack  output  N  one-cycle pulse: client i's byte accepted; client advances data or drops req next cycle
- grant  output  N  one-hot owner of the transmitter; 0 when free
- busy  output  1  high whenever grant != 0
- tx_start  output  1  one-cycle start pulse to `uart_tx`
- tx_data  output  DBIT  byte to `uart_tx` `d_in`; valid in the tx_start cycle
- tx_done  input  1  `uart_tx` `done_tick`

Behaviour:
- Reset values: ack=0, grant=0, busy=0, tx_start=0, tx_data=0, ptr=0, state=IDLE. All outputs are registered.
- State IDLE:
  - If any req is set, pick the winner (below), set grant to the winner one-hot, go to SEND.
  - Otherwise stay in IDLE.
- Winner selection:
  - The first set req bit scanning ptr, ptr+1, … N-1, 0, … ptr-1.
- State SEND:
  - If req[g] is set: tx_start<=1, tx_data<=din slice g, ack<=onehot(g), lastf<=last[g], go to WAIT.
  - If req[g] is clear: hold in SEND with grant kept; the lock persists.
- State WAIT:
  - tx_start and ack return to 0 after one cycle.
  - On tx_done with lastf=1: grant<=0, ptr<=(g+1) mod N, go to IDLE.
  - On tx_done with lastf=0: go to SEND.
- Latency:
  - req rising in IDLE at edge t: grant is visible after edge t+1; tx_start and ack are visible after edge t+2.
  - Byte-to-byte gap: tx_start comes 2 cycles after tx_done.
- tx_done outside WAIT is ignored; no state change.
- Simultaneous events:
  - req from other clients while locked is ignored. Those clients wait; they are never acked.
  - Several reqs in IDLE are resolved by ptr only.
- Single-byte message (last=1 on the first byte): released after one character.
- Wrap-around: ptr=N-1 advances to 0.
- Reset mid-character:
  - The arbiter returns to IDLE immediately.
  - `uart_tx` shares the reset, so no stale tx_done can arrive.
- A client dropping req after its own ack does not release the lock; only a byte flagged last does, or the timeout feature.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT)+1 increments each cycle in SEND while req[g]=0, and clears on leaving SEND or when req[g]=1.
  - When the count reaches TIMEOUT-1: grant<=0, ptr<=(g+1) mod N, go to IDLE, no ack.
- Undefined: no counter exists; the lock is held indefinitely.

Decomposition:
- Shared package `uart_pkg` holds:
  - the state encoding constants IDLE=0, SEND=1, WAIT=2;
  - DBIT default;
  - the clog2 function.
- One natural sub-module: `uart_rr_pick`.
  - Combinational; inputs req[N] and ptr; outputs winner index and a valid flag.
  - Reused by other round-robin blocks.

Test Plan:
- Single client: client 0 sends message 0x48,0x49 (last on 0x49) -> two tx_start pulses with tx_data 0x48 then 0x49, two acks on bit 0; grant=0001 throughout, then 0.
- Round-robin: N=4, clients 1 and 3 both request 1-byte messages from reset -> client 1 served first, then 3; ptr=0 after the second release (3+1 wraps to 0).
- Lock: client 2 is mid-message while client 0 requests -> client 0 gets no ack until client 2's last byte completes; then grant=0001.
- Spurious tx_done pulsed in IDLE and SEND -> no state or output change.
- Reset asserted during WAIT -> next cycle all outputs are 0 and grant=0; after release a new request is served normally from ptr=0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=8: client 1 drops req mid-message -> grant clears exactly 8 cycles after entering SEND and client 2 is granted next. Without the macro, grant stays at 0010.
